// File: rtl/imem_loader.sv
// Serial-to-IMEM loader: packs 4 little-endian bytes per word, writes words 0..N-1, then releases cpu reset.
// 5 cycles per word with rx_valid held high; rx_ready is low outside RECV, so the receiver stalls during WRITE/DONE.
module imem_loader #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_en,
    output logic [ADDR_W-1:0] pc_in,
    output logic [31:0]       data_in,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_byte_idx;
    logic [31:0]       r_buf;
    logic [ADDR_W-1:0] r_pc;
    logic [31:0]       r_data;
    logic              r_cpu_rst_n;
    logic              r_error;

    logic              w_legal;
    logic              w_accept;
    logic              w_last_word;
    logic [31:0]       w_word;

    assign w_legal     = (word_count != '0) && (word_count <= MAX_WORDS);
    assign w_accept    = (r_state == S_RECV) && rx_valid;
    assign w_last_word = ({1'b0, r_addr} == (r_count - CNT_ONE));

    // Buffer with the incoming byte already merged into its lane
    always_comb begin
        w_word = r_buf;
        case (r_byte_idx)
            2'd0:    w_word[7:0]   = rx_data;
            2'd1:    w_word[15:8]  = rx_data;
            2'd2:    w_word[23:16] = rx_data;
            default: w_word[31:24] = rx_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        rx_ready = 1'b0;
        im_en    = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start && w_legal) begin
                    w_next = S_RECV;
                end
            end
            S_RECV: begin
                rx_ready = 1'b1;
                if (w_accept && (r_byte_idx == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                im_en  = 1'b1;
                w_next = w_last_word ? S_DONE : S_RECV;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Write address/data are captured on entry to WRITE and then simply hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_addr      <= '0;
            r_byte_idx  <= '0;
            r_buf       <= '0;
            r_pc        <= '0;
            r_data      <= '0;
            r_cpu_rst_n <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_legal) begin
                            r_error     <= 1'b0;
                            r_count     <= word_count;
                            r_addr      <= '0;
                            r_byte_idx  <= '0;
                            r_cpu_rst_n <= 1'b0;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        r_buf      <= w_word;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (r_byte_idx == 2'd3) begin
                            r_pc   <= r_addr;
                            r_data <= w_word;
                        end
                    end
                end
                S_WRITE: begin
                    if (!w_last_word) begin
                        r_addr <= r_addr + ADDR_ONE;
                    end
                end
                S_DONE: begin
                    r_cpu_rst_n <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign pc_in     = r_pc;
    assign data_in   = r_data;
    assign cpu_rst_n = r_cpu_rst_n;
    assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed timing loads plus randomized loads checked against a byte-stream word model.
module tb_imem_loader;
    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_en;
    logic [ADDR_W-1:0] pc_in;
    logic [31:0]       data_in;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .word_count (word_count),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .im_en      (im_en),
        .pc_in      (pc_in),
        .data_in    (data_in),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cs      = 0;
    int acc_cnt, wr_cnt, done_cnt, first_wr_rel, last_wr_rel, done_rel, last_pc;
    int stall_mode, stall_left;
    logic exp_error, exp_cpu_rst_n;

    logic [7:0]  pend[$];
    logic [7:0]  src_q[$];
    logic [31:0] exp_pc[$];
    logic [31:0] exp_dat[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive_rx();
        bit hold;
        hold = 1'b0;
        if (stall_mode == 1 && $urandom_range(0, 3) == 0) hold = 1'b1;
        if (stall_mode == 2 && acc_cnt == 2 && stall_left > 0) begin
            hold = 1'b1;
            stall_left--;
        end
        if (src_q.size() > 0 && !hold) begin
            rx_valid = 1'b1;
            rx_data  = src_q[0];
        end else begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end
    endtask

    // One clock: handshake decided on settled inputs, outputs observed #1 after the edge
    task automatic tick();
        logic fire;
        fire = rx_valid && rx_ready && !rst;
        @(posedge clk);
        #1;
        cyc++;
        if (fire) begin
            void'(src_q.pop_front());
            acc_cnt++;
        end
        if (im_en) begin
            chk("wr_rdy_low", 32'(rx_ready), 32'd0);
            if (exp_pc.size() == 0) begin
                chk("unexpected_wr", 32'(im_en), 32'd0);
            end else begin
                chk("wr_pc", 32'(pc_in), exp_pc.pop_front());
                chk("wr_dat", data_in, exp_dat.pop_front());
            end
            if (wr_cnt == 0) first_wr_rel = cyc - cs + 1;
            last_wr_rel = cyc - cs + 1;
            last_pc     = 32'(pc_in);
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_rel = cyc - cs + 1;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rx_ready"},  32'(rx_ready),  32'd0);
        chk({tag, "_im_en"},     32'(im_en),     32'd0);
        chk({tag, "_pc_in"},     32'(pc_in),     32'd0);
        chk({tag, "_data_in"},   data_in,        32'd0);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done"},      32'(done),      32'd0);
        chk({tag, "_error"},     32'(error),     32'd0);
    endtask

    // delay < 0 skips cycle-exact timing checks (random stalls)
    task automatic load(input int n, input int mode, input int delay, input bit poke, input bit rnd_wc);
        if (pend.size() == 0) begin
            for (int i = 0; i < 4 * n; i++) pend.push_back(8'($urandom));
        end
        for (int i = 0; i < n; i++) begin
            exp_pc.push_back(32'(i));
            exp_dat.push_back({pend[4*i+3], pend[4*i+2], pend[4*i+1], pend[4*i]});
        end
        foreach (pend[i]) src_q.push_back(pend[i]);
        pend.delete();
        stall_mode   = mode;
        stall_left   = 3;
        acc_cnt      = 0;
        wr_cnt       = 0;
        done_cnt     = 0;
        first_wr_rel = -1;
        last_wr_rel  = -1;
        done_rel     = -1;
        start        = 1'b1;
        word_count   = (ADDR_W+1)'(n);
        drive_rx();
        tick();
        cs            = cyc;
        start         = 1'b0;
        exp_error     = 1'b0;
        exp_cpu_rst_n = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_err", 32'(error), 32'(exp_error));
        chk("start_cpurst", 32'(cpu_rst_n), 32'(exp_cpu_rst_n));
        for (int k = 0; k < 20 * n + 60 && done_cnt == 0; k++) begin
            if (poke && (cyc - cs + 1) == 3) begin
                start      = 1'b1;
                word_count = (ADDR_W+1)'(5);
            end else begin
                start = ($urandom_range(0, 7) == 0) && rnd_wc;
            end
            if (rnd_wc) word_count = (ADDR_W+1)'($urandom);
            drive_rx();
            tick();
            if (done) begin
                chk("done_busy", 32'(busy), 32'd1);
                chk("done_cpurst", 32'(cpu_rst_n), 32'd0);
            end
        end
        chk("done_seen", 32'(done_cnt), 32'd1);
        start    = 1'b0;
        rx_valid = 1'b0;
        tick();
        exp_cpu_rst_n = 1'b1;
        chk("post_cpurst", 32'(cpu_rst_n), 32'(exp_cpu_rst_n));
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_done", 32'(done), 32'd0);
        chk("wr_count", 32'(wr_cnt), 32'(n));
        chk("exp_left", 32'(exp_pc.size()), 32'd0);
        if (delay >= 0) begin
            chk("first_wr_t", 32'(first_wr_rel), 32'(5 + delay));
            chk("last_wr_t", 32'(last_wr_rel), 32'(5 * n + delay));
            chk("done_t", 32'(done_rel), 32'(5 * n + 1 + delay));
        end
    endtask

    task automatic bad_start(input int wc);
        start      = 1'b1;
        word_count = (ADDR_W+1)'(wc);
        rx_valid   = 1'b0;
        tick();
        start     = 1'b0;
        exp_error = 1'b1;
        chk("bad_err", 32'(error), 32'(exp_error));
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_cpurst", 32'(cpu_rst_n), 32'(exp_cpu_rst_n));
        repeat (3) tick();
        chk("bad_sticky", 32'(error), 32'(exp_error));
        chk("bad_idle", 32'(busy), 32'd0);
    endtask

    task automatic push_n2_bytes();
        logic [7:0] b [8];
        b = '{8'h93, 8'h81, 8'h26, 8'h02, 8'h93, 8'h0E, 8'h60, 8'h0C};
        foreach (b[i]) pend.push_back(b[i]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        word_count = '0;
        rx_valid   = 1'b0;
        rx_data    = '0;
        stall_mode = 0;
        acc_cnt    = 0;
        wr_cnt     = 0;
        done_cnt   = 0;
        exp_error     = 1'b0;
        exp_cpu_rst_n = 1'b0;
        repeat (3) tick();
        check_reset("rst");
        rst = 1'b0;
        repeat (2) tick();
        chk("idle_cpurst", 32'(cpu_rst_n), 32'(exp_cpu_rst_n));

        push_n2_bytes();
        load(2, 0, 0, 1'b0, 1'b0);

        push_n2_bytes();
        load(2, 2, 3, 1'b0, 1'b0);

        bad_start(0);
        bad_start(513);
        load(1, 0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
        acc_cnt    = 0;
        stall_mode = 0;
        start      = 1'b1;
        word_count = (ADDR_W+1)'(2);
        drive_rx();
        tick();
        start = 1'b0;
        for (int k = 0; k < 20 && acc_cnt < 2; k++) begin
            drive_rx();
            tick();
        end
        src_q.delete();
        rst      = 1'b1;
        rx_valid = 1'b0;
        tick();
        check_reset("midrst");
        rst           = 1'b0;
        exp_error     = 1'b0;
        exp_cpu_rst_n = 1'b0;
        repeat (3) tick();
        chk("midrst_cpu_held", 32'(cpu_rst_n), 32'(exp_cpu_rst_n));
        pend = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        load(1, 0, 0, 1'b0, 1'b0);

        push_n2_bytes();
        load(2, 0, 0, 1'b1, 1'b0);

        load(512, 0, 0, 1'b0, 1'b0);
        chk("full_last_pc", 32'(last_pc), 32'd511);

        for (int r = 0; r < 8; r++) begin
            if ($urandom_range(0, 2) == 0) bad_start($urandom_range(513, 1023));
            load($urandom_range(1, 24), 1, -1, 1'b0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, 9, word-address width of instruction memory (512 words).
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  load request, sampled only in IDLE.
REQ-005 word_count  input  ADDR_W+1  number of 32-bit words to load; legal range 1..2^ADDR_W.
REQ-006 rx_data  input  8  byte from the serial receiver.
REQ-007 rx_valid  input  1  rx_data holds a valid byte.
REQ-008 rx_ready  output  1  loader accepts a byte; transfer occurs when rx_valid && rx_ready.
REQ-009 im_en  output  1  instruction-memory write strobe.
REQ-010 pc_in  output  ADDR_W  instruction-memory word address.
REQ-011 data_in  output  32  instruction word to write.
REQ-012 cpu_rst_n  output  1  active-low reset to the cpu; low holds the cpu.
REQ-013 busy  output  1  high while a load is in progress.
REQ-014 done  output  1  one-cycle pulse when a load completes.
REQ-015 error  output  1  sticky flag: illegal word_count at start.

Function
REQ-016 FSM states: IDLE, RECV, WRITE, DONE.
REQ-017 IDLE: start=1 with legal word_count -> RECV next cycle; clear error; latch word_count; word address=0; byte index=0; cpu_rst_n=0.
REQ-018 IDLE: start=1 with word_count=0 or >2^ADDR_W -> stay IDLE; set error=1; cpu_rst_n unchanged.
REQ-019 RECV: rx_ready=1; each accepted byte goes into word-buffer lane byte_idx, little-endian (first byte -> [7:0], fourth -> [31:24]); byte_idx increments mod 4.
REQ-020 RECV: when the fourth byte is accepted -> WRITE next cycle; no transfer when rx_valid=0 (state and buffer hold).
REQ-021 WRITE: exactly one cycle: im_en=1, pc_in=current word address, data_in=assembled word; rx_ready=0.
REQ-022 WRITE: if word address = latched count-1 -> DONE, else word address+1 -> RECV.
REQ-023 DONE: one cycle; done=1; cpu_rst_n set to 1 on the following edge and held until the next legal start; -> IDLE.
REQ-024 busy=1 in RECV, WRITE, DONE; 0 in IDLE.
REQ-025 Outside WRITE: im_en=0; pc_in and data_in hold last driven values (don't-care to memory).
REQ-026 start while busy is ignored; word_count changes while busy are ignored.
REQ-027 Throughput: rx_valid held high -> start at cycle T, bytes accepted T+1..T+4, im_en at T+5, next word's first byte at T+6 (5 cycles/word); done at T+5N+1 for N words.
REQ-028 Word address never wraps: max load 2^ADDR_W words ends at address 2^ADDR_W-1.

Reset
REQ-029 rst=1 at any edge, including mid-load -> state IDLE, rx_ready=0, im_en=0, pc_in=0, data_in=0, cpu_rst_n=0, busy=0, done=0, error=0, byte_idx=0, word address=0; partially assembled word discarded.
REQ-030 After rst, the cpu stays in reset until a load completes.

Verification
REQ-031 Load N=2, bytes 93 81 26 02 93 0E 60 0C, rx_valid constant -> im_en at T+5 (pc_in=0, data_in=0x02268193) and T+10 (pc_in=1, data_in=0x0C600E93); done at T+11; cpu_rst_n=1 from T+12.
REQ-032 Same load with rx_valid low for 3 cycles between bytes 2 and 3 -> identical writes, each delayed 3 cycles; buffer unchanged while stalled.
REQ-033 start with word_count=0, then with 513 -> error=1, busy=0, no im_en; next start with word_count=1 clears error.
REQ-034 rst asserted after 2 bytes of word 1 -> next cycle all outputs at reset values; new load of word 0xDEADBEEF (bytes EF BE AD DE) writes pc_in=0, data_in=0xDEADBEEF.
REQ-035 start pulsed during RECV with word_count=5 -> ignored; original N=2 load completes with exactly 2 writes.
REQ-036 Load word_count=512 -> last write pc_in=511, exactly 512 im_en pulses, single done pulse.
